// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// Entry layout, default depth and modulo pointer helper.
package inst_queue_pkg;

    localparam int unsigned INST_QUEUE_DEPTH = 16;
    localparam int unsigned IQ_PC_W          = 32;
    localparam int unsigned IQ_INSTR_W       = 32;

    typedef struct packed {
        logic [IQ_PC_W-1:0]    pc;
        logic [IQ_INSTR_W-1:0] instr;
    } inst_entry_t;

    // depth is a power of two, so the modulo is a mask
    function automatic logic [31:0] ptr_add(
        input logic [31:0] ptr,
        input logic [31:0] n,
        input logic [31:0] depth
    );
        return (ptr + n) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/inst_queue.sv
// inst_queue: multi-lane fetch-to-decode instruction buffer.
// Circular store with FWFT read lanes and full / keep-oldest flush.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = INST_QUEUE_DEPTH,
    parameter int unsigned PUSH_W  = 2,
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned PC_W    = IQ_PC_W,
    parameter int unsigned INSTR_W = IQ_INSTR_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [$clog2(PUSH_W+1)-1:0]         push_cnt,
    input  logic [PUSH_W-1:0][PC_W-1:0]         push_pc,
    input  logic [PUSH_W-1:0][INSTR_W-1:0]      push_instr,
    output logic                                push_ready,
    output logic [ISSUE_W-1:0]                  out_valid,
    output logic [ISSUE_W-1:0][PC_W-1:0]        out_pc,
    output logic [ISSUE_W-1:0][INSTR_W-1:0]     out_instr,
    input  logic [$clog2(ISSUE_W+1)-1:0]        pop_cnt,
    input  logic                                flush,
    input  logic                                flush_keep,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int unsigned CW  = $clog2(DEPTH+1);
    localparam int unsigned PTW = $clog2(DEPTH);

    inst_entry_t    mem_q [DEPTH];
    logic [PTW-1:0] head_q, head_d;
    logic [PTW-1:0] tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  push_req, push_eff;
    logic [CW-1:0]  pop_req, pop_eff;
    logic [CW-1:0]  left;
    logic           wr_en;
    logic [PTW-1:0] rd_ptr [ISSUE_W];

    function automatic logic [PTW-1:0] adv(
        input logic [PTW-1:0] p,
        input logic [CW-1:0]  n
    );
        return PTW'(ptr_add(32'(p), 32'(n), 32'(DEPTH)));
    endfunction

    // Credit only the current occupancy, never a same-cycle pop
    assign push_ready = (count_q <= CW'(DEPTH - PUSH_W));
    assign count      = count_q;

    always_comb begin
        push_req = (CW'(push_cnt) > CW'(PUSH_W)) ? CW'(PUSH_W) : CW'(push_cnt);
        push_eff = push_ready ? push_req : '0;
        pop_req  = (CW'(pop_cnt) > CW'(ISSUE_W)) ? CW'(ISSUE_W) : CW'(pop_cnt);
        pop_eff  = (pop_req > count_q) ? count_q : pop_req;
        left     = count_q - pop_eff;
        wr_en    = !flush && !flush_keep;
        head_d   = adv(head_q, pop_eff);
        tail_d   = adv(tail_q, push_eff);
        count_d  = count_q + push_eff - pop_eff;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (flush_keep) begin
            count_d = (left != '0) ? CW'(1) : '0;
            tail_d  = adv(head_d, count_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            for (int j = 0; j < PUSH_W; j++) begin
                if (CW'(j) < push_eff) begin
                    mem_q[adv(tail_q, CW'(j))] <= '{
                        pc:    IQ_PC_W'(push_pc[j]),
                        instr: IQ_INSTR_W'(push_instr[j])
                    };
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            rd_ptr[i]    = adv(head_q, CW'(i));
            out_valid[i] = (count_q > CW'(i));
            out_pc[i]    = PC_W'(mem_q[rd_ptr[i]].pc);
            out_instr[i] = INSTR_W'(mem_q[rd_ptr[i]].instr);
        end
    end

endmodule
